// File: rtl/send_packet_sched_pkg.sv
// Shared types and helpers for the multi-channel packet-send scheduler.
package send_packet_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } sched_state_t;

  localparam int STAT_W = 16;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pkt_cmd_fifo.sv
// Per-channel command FIFO holding RAM start addresses.
// Latency: push visible at the head one cycle later; head is read combinationally.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module pkt_cmd_fifo #(
  parameter  int W     = 25,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_wr;
  logic          w_rd;

  assign full  = (r_cnt == FULL_CNT);
  assign empty = (r_cnt == '0);
  assign count = r_cnt;
  assign dout  = r_mem[r_rd];
  assign w_rd  = pop && !empty;
  // A pop frees the slot the write lands in, so a full push with pop is accepted.
  assign w_wr  = push && (!full || w_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + 1'b1;
      if (w_rd) r_rd <= r_rd + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr] <= din;
  end

endmodule

// File: rtl/send_packet_sched.sv
// Round-robin scheduler feeding one TX engine from NUM_CH command queues; SEND_PACKET_SCHED_STATS_EN adds per-channel counters.
// Latency: push to tx_valid is 2 cycles when idle; tx_done to next tx_valid is 2 cycles.
// Backpressure: tx_valid/tx_addr held until tx_ready; one command in flight until tx_done.
module send_packet_sched
  import send_packet_sched_pkg::*;
#(
  parameter  int NUM_CH      = 2,
  parameter  int ADDR_W      = 25,
  parameter  int QUEUE_DEPTH = 4,
  localparam int CH_W        = ch_w(NUM_CH)
) (
  input  logic                     clock_clk,
  input  logic                     reset_reset_n,
  input  logic                     mac_inited,
  input  logic [NUM_CH-1:0]        cmd_send,
  input  logic [NUM_CH*ADDR_W-1:0] start_ram_addr,
  output logic [NUM_CH-1:0]        cmd_full,
  output logic [NUM_CH-1:0]        cmd_drop,
  output logic                     tx_valid,
  output logic [ADDR_W-1:0]        tx_addr,
  output logic [CH_W-1:0]          tx_ch,
  input  logic                     tx_ready,
  input  logic                     tx_done,
  output logic                     busy
`ifdef SEND_PACKET_SCHED_STATS_EN
  ,
  output logic [NUM_CH*STAT_W-1:0] sent_count,
  output logic [NUM_CH*STAT_W-1:0] drop_count
`endif
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  sched_state_t      r_state;
  sched_state_t      w_state_nxt;
  logic [CH_W-1:0]   r_grant;
  logic [CH_W-1:0]   w_grant_nxt;
  logic [CH_W-1:0]   r_rr_ptr;
  logic [CH_W-1:0]   w_rr_nxt;
  logic [CH_W-1:0]   w_pick;
  logic              w_any;
  logic              w_hs;
  logic [NUM_CH-1:0] w_empty;
  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_pop;
  logic [NUM_CH-1:0] w_push_rej;
  logic [NUM_CH-1:0] r_drop;
  logic [ADDR_W-1:0] w_head [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_q
    logic [CNT_W-1:0] w_cnt;

    pkt_cmd_fifo #(
      .W     (ADDR_W),
      .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
      .clk   (clock_clk),
      .rst_n (reset_reset_n),
      .push  (cmd_send[c]),
      .pop   (w_pop[c]),
      .din   (start_ram_addr[c*ADDR_W +: ADDR_W]),
      .dout  (w_head[c]),
      .full  (w_full[c]),
      .empty (w_empty[c]),
      .count (w_cnt)
    );

    assign w_pop[c]      = w_hs && (r_grant == CH_W'(c));
    assign w_push_rej[c] = cmd_send[c] && w_full[c] && !w_pop[c];
    assign cmd_full[c]   = (w_cnt == CNT_W'(QUEUE_DEPTH));
  end

  assign cmd_drop = r_drop;

  // Descending scan so the channel closest to rr_ptr wins.
  always_comb begin
    int w_sum;
    w_sum  = 0;
    w_pick = r_rr_ptr;
    w_any  = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      w_sum = int'(r_rr_ptr) + i;
      if (w_sum >= NUM_CH) w_sum = w_sum - NUM_CH;
      if (!w_empty[CH_W'(w_sum)]) begin
        w_pick = CH_W'(w_sum);
        w_any  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_drop   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_drop   <= w_push_rej;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr_ptr;
    w_hs        = 1'b0;
    tx_valid    = 1'b0;
    tx_addr     = '0;
    tx_ch       = '0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (mac_inited && w_any) begin
          w_grant_nxt = w_pick;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        tx_valid = 1'b1;
        tx_addr  = w_head[r_grant];
        tx_ch    = r_grant;
        if (tx_ready) begin
          w_hs        = 1'b1;
          w_state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          w_rr_nxt    = (r_grant == CH_W'(NUM_CH - 1)) ? '0 : r_grant + CH_W'(1);
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef SEND_PACKET_SCHED_STATS_EN
  logic w_done_acc;
  assign w_done_acc = (r_state == WAIT_DONE) && tx_done;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_stats
    logic [STAT_W-1:0] r_sent;
    logic [STAT_W-1:0] r_dropc;

    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
        r_sent  <= '0;
        r_dropc <= '0;
      end else begin
        if (w_done_acc && (r_grant == CH_W'(c)) && (r_sent != '1)) r_sent <= r_sent + 1'b1;
        if (r_drop[c] && (r_dropc != '1)) r_dropc <= r_dropc + 1'b1;
      end
    end

    assign sent_count[c*STAT_W +: STAT_W] = r_sent;
    assign drop_count[c*STAT_W +: STAT_W] = r_dropc;
  end
`endif

endmodule
